// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_t;

   localparam int ST_FULL    = 0;
   localparam int ST_EMPTY   = 1;
   localparam int ST_BUSY    = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_CNT_LSB = 8;

   localparam logic [31:0] DEF_TX_ADDR   = 32'h1000_0000;
   localparam logic [31:0] DEF_STAT_ADDR = 32'h1000_0004;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fall-through read data.
// A push into a full FIFO is taken only alongside a pop.
module sync_fifo #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Store-driven 8N1 UART transmitter on the core data-memory port,
// with a pollable status word.
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter logic [31:0] TX_ADDR      = DEF_TX_ADDR,
   parameter logic [31:0] STAT_ADDR    = DEF_STAT_ADDR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        sel,
   output logic [31:0] rdata,
   output logic        tx,
   output logic        busy
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   uart_state_t      state_q, state_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic [2:0]       bit_q, bit_n;
   logic [7:0]       shreg_q, shreg_n;
   logic             tx_n;
   logic             ovf_q;

   logic             hit_tx;
   logic             hit_stat;
   logic             push;
   logic             pop;
   logic [7:0]       fifo_dout;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_count;
   logic             unused_wdata;

   assign hit_tx       = (addr == TX_ADDR);
   assign hit_stat     = (addr == STAT_ADDR);
   assign sel          = hit_tx || hit_stat;
   assign push         = mem_write && hit_tx;
   assign unused_wdata = ^{wdata[31:8]};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (wdata[7:0]),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      rdata = '0;
      if (hit_stat) begin
         rdata[ST_FULL]           = fifo_full;
         rdata[ST_EMPTY]          = fifo_empty;
         rdata[ST_BUSY]           = busy;
         rdata[ST_OVF]            = ovf_q;
         rdata[ST_CNT_LSB +: CW]  = fifo_count;
      end
   end

   // A dropped push outranks a clear landing on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (push && fifo_full && !pop) begin
         ovf_q <= 1'b1;
      end else if (mem_write && hit_stat && wdata[ST_OVF]) begin
         ovf_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx      <= 1'b1;
         busy    <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         bit_q   <= bit_n;
         shreg_q <= shreg_n;
         tx      <= tx_n;
         busy    <= (state_n != IDLE);
      end
   end

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      bit_n   = bit_q;
      shreg_n = shreg_q;
      tx_n    = tx;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_n = '0;
            tx_n  = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shreg_n = fifo_dout;
               tx_n    = 1'b0;
               state_n = START;
            end
         end
         START: begin
            if (cnt_q == CNT_LAST) begin
               cnt_n   = '0;
               bit_n   = '0;
               tx_n    = shreg_q[0];
               state_n = DATA;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_n = '0;
               if (bit_q == 3'd7) begin
                  tx_n    = 1'b1;
                  state_n = STOP;
               end else begin
                  bit_n   = bit_q + 1'b1;
                  shreg_n = shreg_q >> 1;
                  tx_n    = shreg_q[1];
               end
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_n = '0;
               // Chain straight into the next start bit when data waits.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shreg_n = fifo_dout;
                  tx_n    = 1'b0;
                  state_n = START;
               end else begin
                  tx_n    = 1'b1;
                  state_n = IDLE;
               end
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: bytes stored are queued and
// compared against frames decoded from the serial line.
module tb_mmio_uart_tx;

   localparam logic [31:0] TXA = 32'h1000_0000;
   localparam logic [31:0] STA = 32'h1000_0004;

   logic        clk;
   logic        rst;
   logic        mem_write;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        sel;
   logic [31:0] rdata;
   logic        tx;
   logic        busy;

   int          vectors;
   int          errs;
   int          cyc;
   int          frames_done;
   int          starts[$];
   logic [7:0]  sb[$];

   mmio_uart_tx #(
      .CLKS_PER_BIT (4),
      .FIFO_DEPTH   (4),
      .TX_ADDR      (TXA),
      .STAT_ADDR    (STA)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_write (mem_write),
      .addr      (addr),
      .wdata     (wdata),
      .sel       (sel),
      .rdata     (rdata),
      .tx        (tx),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [31:0] a,
                        input logic [31:0] d);
      mem_write = we;
      addr      = a;
      wdata     = d;
      @(negedge clk);
   endtask

   task automatic peek_stat();
      mem_write = 1'b0;
      addr      = STA;
      wdata     = '0;
      #1;
   endtask

   task automatic wait_frames(input int n);
      int t;
      t = 0;
      while (frames_done < n && t < 600) begin
         @(negedge clk);
         t++;
      end
      check("frames_done", frames_done, n);
   endtask

   // Line monitor: decodes one 40-sample frame per falling start bit.
   logic [39:0] samp;
   logic        ab;
   logic        bad;
   logic [7:0]  rx;
   int          st;

   always begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
         samp    = '0;
         samp[0] = tx;
         ab      = 1'b0;
         st      = cyc;
         for (int i = 1; i < 40; i++) begin
            @(negedge clk);
            if (rst) ab = 1'b1;
            samp[i] = tx;
         end
         if (!ab) begin
            bad = 1'b0;
            for (int i = 0; i < 4; i++) begin
               if (samp[i] !== 1'b0 || samp[36+i] !== 1'b1) bad = 1'b1;
            end
            for (int b = 0; b < 8; b++) begin
               rx[b] = samp[4+4*b];
               for (int k = 1; k < 4; k++) begin
                  if (samp[4+4*b+k] !== rx[b]) bad = 1'b1;
               end
            end
            starts.push_back(st);
            check("frame_shape", {31'b0, bad}, 32'd0);
            if (sb.size() == 0)
               check("extra_frame", {24'b0, rx}, 32'hFFFF_FFFF);
            else
               check("rx_byte", {24'b0, rx}, {24'b0, sb.pop_front()});
            frames_done++;
         end
      end
   end

   initial begin
      vectors     = 0;
      errs        = 0;
      cyc         = 0;
      frames_done = 0;
      mem_write   = 1'b0;
      addr        = '0;
      wdata       = '0;
      rst         = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      peek_stat();
      check("rst_tx", {31'b0, tx}, 32'd1);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_stat", rdata, 32'h0000_0002);
      check("sel_stat", {31'b0, sel}, 32'd1);
      addr = 32'h1000_0008;
      #1;
      check("sel_other", {31'b0, sel}, 32'd0);
      check("rdata_other", rdata, 32'd0);
      @(negedge clk);

      sb.push_back(8'h55);
      drive(1'b1, TXA, 32'hFFFF_FF55);
      peek_stat();
      check("one_stat_e0", rdata, 32'h0000_0100);
      check("one_tx_e0", {31'b0, tx}, 32'd1);
      @(negedge clk);
      check("one_tx_e1", {31'b0, tx}, 32'd0);
      check("one_busy_e1", {31'b0, busy}, 32'd1);
      wait_frames(1);
      @(negedge clk);
      check("one_busy_end", {31'b0, busy}, 32'd0);
      check("one_stat_end", rdata, 32'h0000_0002);

      sb.push_back(8'hA5);
      sb.push_back(8'h3C);
      drive(1'b1, TXA, 32'h0000_00A5);
      drive(1'b1, TXA, 32'h0000_003C);
      peek_stat();
      repeat (3) @(negedge clk);
      #1;
      check("b2b_stat", rdata, 32'h0000_0104);
      wait_frames(3);
      if (starts.size() >= 3)
         check("b2b_gap", starts[2] - starts[1], 32'd40);
      @(negedge clk);
      check("b2b_busy_end", {31'b0, busy}, 32'd0);

      sb.push_back(8'h11);
      drive(1'b1, TXA, 32'h0000_0011);
      repeat (3) drive(1'b0, 32'd0, 32'd0);
      for (int i = 0; i < 6; i++) begin
         if (i < 4) sb.push_back(8'h21 + 8'(i));
         drive(1'b1, TXA, 32'h21 + i);
      end
      peek_stat();
      check("ovf_stat", rdata, 32'h0000_040D);
      drive(1'b1, STA, 32'h0000_0008);
      peek_stat();
      check("ovf_clr", rdata, 32'h0000_0405);
      drive(1'b1, TXA, 32'h0000_0099);
      peek_stat();
      check("ovf_reset", rdata, 32'h0000_040D);
      drive(1'b1, STA, 32'h0000_0007);
      peek_stat();
      check("ovf_noclr", rdata, 32'h0000_040D);
      drive(1'b1, STA, 32'h0000_0008);
      peek_stat();
      check("ovf_clr2", rdata, 32'h0000_0405);
      wait_frames(8);
      @(negedge clk);
      check("ovf_stat_end", rdata, 32'h0000_0002);

      drive(1'b1, TXA, 32'h0000_000F);
      drive(1'b1, TXA, 32'h0000_00F0);
      peek_stat();
      repeat (17) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_tx", {31'b0, tx}, 32'd1);
      check("mid_rst_busy", {31'b0, busy}, 32'd0);
      check("mid_rst_stat", rdata, 32'h0000_0002);
      sb.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      check("mid_no_resume", frames_done, 32'd8);
      check("mid_tx_idle", {31'b0, tx}, 32'd1);
      check("mid_stat", rdata, 32'h0000_0002);
      check("sb_drained", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
